// File: rtl/r6_out_serializer.sv
// Radix-6 frame unloader: captures six complex lanes per input handshake and emits them lane 0 first.
// First beat appears the cycle after capture; out_ready=0 freezes all outputs; the last-beat accept can take the next frame.
module r6_out_serializer #(
   parameter int W     = 32,
   parameter int LANES = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [LANES*W-1:0] in_re,
   input  logic [LANES*W-1:0] in_img,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [W-1:0]       out_re,
   output logic [W-1:0]       out_img,
   output logic [2:0]         out_idx,
   output logic               out_last
);
   localparam logic [2:0] LAST_IDX = 3'(LANES - 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t             state_q;
   logic [LANES*W-1:0] hold_re_q, hold_img_q;
   logic               out_valid_q, out_last_q;
   logic [W-1:0]       out_re_q, out_img_q;
   logic [2:0]         out_idx_q;

   logic [2:0]         idx_d;
   logic [W-1:0]       re_d, img_d;
   logic               take;

   // A new frame may enter while idle, or on the very edge that retires the last lane.
   assign in_ready = ~rst & ((state_q == IDLE) |
                             ((state_q == SEND) & (out_idx_q == LAST_IDX) & out_ready));
   assign take     = in_valid & in_ready;
   assign idx_d    = out_idx_q + 3'd1;

   always_comb begin
      re_d  = '0;
      img_d = '0;
      for (int k = 0; k < LANES; k++) begin
         if (idx_d == 3'(k)) begin
            re_d  = hold_re_q[k*W +: W];
            img_d = hold_img_q[k*W +: W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         hold_re_q   <= '0;
         hold_img_q  <= '0;
         out_valid_q <= 1'b0;
         out_re_q    <= '0;
         out_img_q   <= '0;
         out_idx_q   <= '0;
         out_last_q  <= 1'b0;
      end else if (take) begin
         state_q     <= SEND;
         hold_re_q   <= in_re;
         hold_img_q  <= in_img;
         out_valid_q <= 1'b1;
         out_re_q    <= in_re[W-1:0];
         out_img_q   <= in_img[W-1:0];
         out_idx_q   <= '0;
         out_last_q  <= 1'b0;
      end else if ((state_q == SEND) && out_ready) begin
         if (out_idx_q == LAST_IDX) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
         end else begin
            out_idx_q  <= idx_d;
            out_re_q   <= re_d;
            out_img_q  <= img_d;
            out_last_q <= (idx_d == LAST_IDX);
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_re    = out_re_q;
   assign out_img   = out_img_q;
   assign out_idx   = out_idx_q;
   assign out_last  = out_last_q;
endmodule
